// File: rtl/modular_inverse_if.sv
// Start/result handshake bundle shared by the modular inverse block and its requester.
interface modular_inverse_if #(
  parameter int WIDTH = 16
);
  logic             ready_in;
  logic [WIDTH-1:0] value_in;
  logic [WIDTH-1:0] modulus_in;
  logic [WIDTH-1:0] value_out;
  logic             exists_out;
  logic             busy_out;
  logic             valid_out;

  modport master (
    output ready_in, value_in, modulus_in,
    input  value_out, exists_out, busy_out, valid_out
  );

  modport slave (
    input  ready_in, value_in, modulus_in,
    output value_out, exists_out, busy_out, valid_out
  );
endinterface

// File: rtl/modular_inverse.sv
// Modular inverse d = a^-1 mod m by iterative extended Euclid; each quotient comes
// from a WIDTH-cycle restoring divider that is shared with the initial a mod m reduction.
module modular_inverse #(
  parameter int WIDTH = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  modular_inverse_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TRIV   = 3'd1;
  localparam logic [2:0] S_REDUCE = 3'd2;
  localparam logic [2:0] S_DIVIDE = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_FINAL  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic [WIDTH-1:0]        r_m;
  logic [WIDTH-1:0]        r_r0;
  logic [WIDTH-1:0]        r_r1;
  logic signed [WIDTH:0]   r_t0;
  logic signed [WIDTH:0]   r_t1;
  logic [WIDTH-1:0]        r_quo;
  logic [WIDTH:0]          r_rem;
  logic [WIDTH-1:0]        r_res_value;
  logic                    r_res_exists;
  logic [WIDTH-1:0]        r_value;
  logic                    r_exists;
  logic                    r_busy;
  logic                    r_valid;

  logic [WIDTH-1:0]        w_divisor;
  logic [WIDTH:0]          w_rem_sh;
  logic                    w_ge;
  logic [WIDTH:0]          w_rem_nx;
  logic [WIDTH-1:0]        w_quo_nx;

  // t0 - q*t1: full 2*WIDTH+1 product, truncation to WIDTH+1 is exact since |t| <= m.
  function automatic logic signed [WIDTH:0] next_t(
    input logic signed [WIDTH:0] t0,
    input logic signed [WIDTH:0] t1,
    input logic [WIDTH-1:0]      q
  );
    logic signed [2*WIDTH:0] qx;
    logic signed [2*WIDTH:0] tx;
    logic signed [WIDTH:0]   prod;
    qx   = $signed({{(WIDTH+1){1'b0}}, q});
    tx   = $signed({{WIDTH{t1[WIDTH]}}, t1});
    prod = (WIDTH+1)'(qx * tx);
    return t0 - prod;
  endfunction

  // Map a Bezout coefficient in [-m, m) into [0, m).
  function automatic logic [WIDTH-1:0] fold_t(
    input logic signed [WIDTH:0] t,
    input logic [WIDTH-1:0]      m
  );
    return WIDTH'(t[WIDTH] ? (t + $signed({1'b0, m})) : t);
  endfunction

  always_comb begin
    w_divisor = (r_state == S_REDUCE) ? r_m : r_r1;
    w_rem_sh  = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    w_ge      = (w_rem_sh >= {1'b0, w_divisor});
    w_rem_nx  = w_ge ? (w_rem_sh - {1'b0, w_divisor}) : w_rem_sh;
    w_quo_nx  = {r_quo[WIDTH-2:0], w_ge};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_m          <= '0;
      r_r0         <= '0;
      r_r1         <= '0;
      r_t0         <= '0;
      r_t1         <= '0;
      r_quo        <= '0;
      r_rem        <= '0;
      r_res_value  <= '0;
      r_res_exists <= 1'b0;
      r_value      <= '0;
      r_exists     <= 1'b0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The result cycle itself (r_valid high) never accepts a new request.
          if (bus.ready_in && !r_valid) begin
            r_m     <= bus.modulus_in;
            r_r0    <= bus.modulus_in;
            r_r1    <= '0;
            r_t0    <= '0;
            r_t1    <= '0;
            r_quo   <= bus.value_in;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= (bus.modulus_in[WIDTH-1:1] == '0) ? S_TRIV : S_REDUCE;
          end
        end
        S_TRIV: begin
          // m<=1: r0=m and t0=0 already give (0,0) for m=0 and (0,1) for m=1 in FINAL.
          r_state <= S_FINAL;
        end
        S_REDUCE: begin
          if (r_cnt != LAST_CNT) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_r1    <= r_rem[WIDTH-1:0];
            r_t0    <= '0;
            r_t1    <= {{WIDTH{1'b0}}, 1'b1};
            r_quo   <= r_m;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= (r_rem == '0) ? S_FINAL : S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_r0    <= r_r1;
          r_r1    <= r_rem[WIDTH-1:0];
          r_t0    <= r_t1;
          r_t1    <= next_t(r_t0, r_t1, r_quo);
          r_quo   <= r_r1;
          r_rem   <= '0;
          r_cnt   <= '0;
          r_state <= (r_rem == '0) ? S_FINAL : S_DIVIDE;
        end
        S_FINAL: begin
          if (r_r0 == WIDTH'(1)) begin
            r_res_value  <= fold_t(r_t0, r_m);
            r_res_exists <= 1'b1;
          end else begin
            r_res_value  <= '0;
            r_res_exists <= 1'b0;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_value  <= r_res_value;
          r_exists <= r_res_exists;
          r_busy   <= 1'b0;
          r_valid  <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.value_out  = r_value;
  assign bus.exists_out = r_exists;
  assign bus.busy_out   = r_busy;
  assign bus.valid_out  = r_valid;
endmodule
